inp_feeder: RTL

- Downstream consumer of the banked input memory (INPMEM).
- On a start command, streams a tile of K input vectors out of the memory. Each vector is ROWS consecutive bytes.
- Issues one byte read per cycle and gathers the bytes into a ROWS-lane vector.
- Presents each vector to the systolic array row inputs over a valid/ready handshake.

---
 rtl/inp_feeder_pkg.sv | 16 +
 rtl/inp_feeder_skew.sv | 30 +++
 rtl/inp_feeder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/inp_feeder_pkg.sv
// Shared definitions for the INPMEM input feeder: FSM state encoding and
// default geometry shared with the INPMEM instantiation.
package inp_feeder_pkg;

  localparam int unsigned INP_ADDR_W_DEF = 16;
  localparam int unsigned INP_ROWS_DEF   = 4;
  localparam int unsigned INP_STEP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/inp_feeder_skew.sv
// inp_skew: 8-bit delay line of DEPTH stages that advances only when en=1.
// clr zeroes every stage so a new tile starts with an empty wavefront.
module inp_skew #(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [DEPTH-1:0][7:0] stage;

  // Shift one byte in per accepted beat; clear on reset or new tile.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      stage <= '0;
    end else if (en) begin
      stage[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/inp_feeder.sv
// inp_feeder: streams K vectors of ROWS bytes out of INPMEM, one byte read per
// cycle, and presents them to the systolic array over valid/ready.
// Optional diagonal skew + zero flush when INP_FEEDER_SKEW_EN is defined.
// mem_cen is the only combinational output: its stall term depends on the
// consumer's vec_ready in the same cycle.
module inp_feeder
  import inp_feeder_pkg::*;
#(
  parameter int unsigned ADDR_W = INP_ADDR_W_DEF,
  parameter int unsigned ROWS   = INP_ROWS_DEF,
  parameter int unsigned STEP_W = INP_STEP_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [STEP_W-1:0]   num_steps,
  output logic                mem_cen,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_a,
  input  logic [7:0]          mem_q,
  output logic [ROWS*8-1:0]   vec_data,
  output logic                vec_valid,
  input  logic                vec_ready,
  output logic                vec_last,
  output logic                busy,
  output logic                done
);

  localparam int unsigned LANE_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CNT_W  = STEP_W + LANE_W + 1;

  state_t                  state;
  logic [STEP_W-1:0]       k_reg;
  logic [ADDR_W-1:0]       addr;
  logic [CNT_W-1:0]        issue_cnt;
  logic [CNT_W-1:0]        load_cnt;
  logic                    rd_pend;
  logic [LANE_W-1:0]       cap_lane;
  logic [ROWS-1:0][7:0]    gather;
  logic                    gather_full;
  logic [ROWS*8-1:0]       cur_vec;

  logic                    accept;
  logic                    out_free;
  logic                    complete_now;
  logic                    issue;
  logic [CNT_W-1:0]        total_reads;
  logic [CNT_W-1:0]        last_idx;

  // Handshake, stall and issue decisions for the current cycle.
  always_comb begin
    accept       = vec_valid & vec_ready;
    out_free     = ~vec_valid | vec_ready;
    complete_now = rd_pend & (cap_lane == LANE_W'(ROWS - 1));
    total_reads  = CNT_W'(k_reg) * CNT_W'(ROWS);
`ifdef INP_FEEDER_SKEW_EN
    last_idx     = CNT_W'(k_reg) + CNT_W'(ROWS - 1) - CNT_W'(1);
`else
    last_idx     = CNT_W'(k_reg) - CNT_W'(1);
`endif
    issue        = (state == ST_FETCH) && (issue_cnt != total_reads) &&
                   !gather_full && !(complete_now && !out_free);
  end

  assign mem_cen = ~issue;
  assign mem_wen = 1'b1;
  assign mem_a   = addr;

  // Main FSM: read issue, byte gather, output register and tile control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      k_reg       <= '0;
      addr        <= '0;
      issue_cnt   <= '0;
      load_cnt    <= '0;
      rd_pend     <= 1'b0;
      cap_lane    <= '0;
      gather      <= '0;
      gather_full <= 1'b0;
      cur_vec     <= '0;
      vec_valid   <= 1'b0;
      vec_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            k_reg       <= num_steps;
            addr        <= base_addr;
            issue_cnt   <= '0;
            load_cnt    <= '0;
            rd_pend     <= 1'b0;
            cap_lane    <= '0;
            gather      <= '0;
            gather_full <= 1'b0;
            busy        <= 1'b1;
            state       <= (num_steps == '0) ? ST_DONE : ST_FETCH;
          end
        end

        ST_FETCH: begin
          rd_pend <= issue;
          if (issue) begin
            addr      <= addr + ADDR_W'(1);
            issue_cnt <= issue_cnt + CNT_W'(1);
          end
          if (rd_pend) begin
            cap_lane <= complete_now ? '0 : cap_lane + LANE_W'(1);
          end

          if (complete_now) begin
            if (out_free) begin
              cur_vec   <= {mem_q, gather[ROWS-2:0]};
              vec_valid <= 1'b1;
              vec_last  <= (load_cnt == last_idx);
              load_cnt  <= load_cnt + CNT_W'(1);
            end else begin
              gather[ROWS-1] <= mem_q;
              gather_full    <= 1'b1;
            end
          end else begin
            if (rd_pend) begin
              gather[cap_lane] <= mem_q;
            end
            if (gather_full && accept) begin
              cur_vec     <= gather;
              vec_valid   <= 1'b1;
              vec_last    <= (load_cnt == last_idx);
              load_cnt    <= load_cnt + CNT_W'(1);
              gather_full <= 1'b0;
            end else if (accept) begin
              vec_valid <= 1'b0;
              vec_last  <= 1'b0;
            end
          end

          if (accept && !gather_full && (load_cnt == CNT_W'(k_reg))) begin
`ifdef INP_FEEDER_SKEW_EN
            state <= ST_FLUSH;
`else
            state <= ST_DONE;
`endif
          end
        end

        ST_FLUSH: begin
`ifdef INP_FEEDER_SKEW_EN
          if (out_free && (load_cnt != last_idx + CNT_W'(1))) begin
            cur_vec   <= '0;
            vec_valid <= 1'b1;
            vec_last  <= (load_cnt == last_idx);
            load_cnt  <= load_cnt + CNT_W'(1);
          end else if (accept) begin
            vec_valid <= 1'b0;
            vec_last  <= 1'b0;
          end
          if (accept && vec_last) begin
            state <= ST_DONE;
          end
`else
          state <= ST_IDLE;
          busy  <= 1'b0;
`endif
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef INP_FEEDER_SKEW_EN
  logic skew_clr;
  assign skew_clr = (state == ST_IDLE) && start;

  // Lane 0 is undelayed; lane r is delayed r accepted beats.
  assign vec_data[7:0] = cur_vec[7:0];
  for (genvar r = 1; r < int'(ROWS); r++) begin : g_skew
    inp_skew #(
      .DEPTH (int unsigned'(r))
    ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .clr   (skew_clr),
      .din   (cur_vec[8*r +: 8]),
      .dout  (vec_data[8*r +: 8])
    );
  end
`else
  assign vec_data = cur_vec;
`endif

endmodule
